// File: rtl/seg_scan_driver_if.sv
// Bundles the display data/strobe inputs and the multiplexed LED outputs.
//   value    : four hex nibbles, value[3:0] is digit 0 (rightmost)
//   load     : capture strobe for value/dp_en
//   blank_lz : blank leading zeros when 1
//   dp_en    : decimal-point enable per digit
//   seg      : segment drive, active-low, seg[0]=a .. seg[6]=g
//   dp       : decimal-point drive, active-low
//   an       : digit enable, active-low
//   frame    : one-cycle pulse at the frame boundary
interface seg_scan_driver_if;
   logic [15:0] value;
   logic        load;
   logic        blank_lz;
   logic [3:0]  dp_en;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame;

   modport master (
      output value, load, blank_lz, dp_en,
      input  seg, dp, an, frame
   );

   modport slave (
      input  value, load, blank_lz, dp_en,
      output seg, dp, an, frame
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with guard gaps and
// frame-synchronous display updates.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : seg_scan_driver_if.slave (data in, segment/anode/frame out)
//
// state   | meaning
// --------+--------------------------------------------------
// S_SHOW  | digit idx lit for DIV cycles
// S_GUARD | all digits off for GUARD cycles, then next digit
module seg_scan_driver #(
   parameter int unsigned DIV   = 1000,
   parameter int unsigned GUARD = 16
) (
   input  logic              clk,
   input  logic              reset,
   seg_scan_driver_if.slave  bus
);

   typedef enum logic {S_SHOW = 1'b0, S_GUARD = 1'b1} state_t;

   localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
   localparam logic [15:0] GUARD_LAST = 16'(GUARD - 1);

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   // run_q holds the scan for the first edge after reset so that edge
   // starts SHOW of digit 0 rather than advancing through it.
   logic        run_q;
   logic        wrap;
   // {dp_en, value}
   logic [19:0] shadow_q, disp_q;

   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic [3:0]  an_q, an_d;
   logic        frame_q;

   logic [3:0]  nib;
   logic        hi_zero;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wrap    = 1'b0;
      if (run_q) begin
         case (state_q)
            S_SHOW: begin
               if (cnt_q == DIV_LAST) begin
                  state_d = S_GUARD;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            default: begin
               if (cnt_q == GUARD_LAST) begin
                  state_d = S_SHOW;
                  cnt_d   = 16'd0;
                  idx_d   = idx_q + 2'd1;
                  wrap    = (idx_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         endcase
      end
   end

   // Pin decode from the current state; registered below for one-cycle latency.
   always_comb begin
      nib = disp_q[4*idx_q +: 4];
      case (idx_q)
         2'd3:    hi_zero = (disp_q[15:12] == 4'h0);
         2'd2:    hi_zero = (disp_q[15:8]  == 8'h00);
         2'd1:    hi_zero = (disp_q[15:4]  == 12'h000);
         default: hi_zero = 1'b0;
      endcase
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (run_q && state_q == S_SHOW) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = (bus.blank_lz && hi_zero) ? 7'h7F : ~hex7(nib);
         dp_d  = ~disp_q[16 + 32'(idx_q)];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_SHOW;
         idx_q    <= 2'd0;
         cnt_q    <= 16'd0;
         run_q    <= 1'b0;
         shadow_q <= 20'd0;
         disp_q   <= 20'd0;
         an_q     <= 4'b1111;
         seg_q    <= 7'h7F;
         dp_q     <= 1'b1;
         frame_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         run_q   <= 1'b1;
         // Display takes the pre-edge shadow, so a coincident load lands next frame.
         if (wrap)
            disp_q <= shadow_q;
         if (bus.load)
            shadow_q <= {bus.dp_en, bus.value};
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         frame_q <= wrap;
      end
   end

   assign bus.an    = an_q;
   assign bus.seg   = seg_q;
   assign bus.dp    = dp_q;
   assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

   localparam int DIV    = 4;
   localparam int GRD    = 1;
   localparam int SLOT   = DIV + GRD;
   localparam int FRAMEC = 4 * SLOT;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       frame;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   seg_scan_driver_if bus ();

   seg_scan_driver #(.DIV(DIV), .GUARD(GRD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   exp_t sb_q[$];

   int ecnt;
   logic [19:0] mdisp, mshadow;
   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: cycle position inside the 20-cycle frame, counted in edges
   // since reset release. Edge 1 starts the scan; pins lag state by one edge.
   task automatic model_edge();
      exp_t e;
      int slot, dig;
      logic [15:0] v;
      ecnt++;
      e.an = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1;
      e.frame = (ecnt > 1) && ((ecnt - 1) % FRAMEC == 0);
      if (ecnt >= 2) begin
         slot = (ecnt - 2) % FRAMEC;
         dig  = slot / SLOT;
         if (slot % SLOT < DIV) begin
            v = mdisp[15:0];
            e.an = ~(4'b0001 << dig);
            if (bus.blank_lz && dig > 0 && (v >> (4 * dig)) == 16'd0)
               e.seg = 7'h7F;
            else
               e.seg = ~hex_tab[(v >> (4 * dig)) & 16'hF];
            e.dp = ~mdisp[16 + dig];
         end
      end
      sb_q.push_back(e);
      if (e.frame) mdisp = mshadow;
      if (bus.load) mshadow = {bus.dp_en, bus.value};
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset) model_edge();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      bus.value = v; bus.dp_en = d; bus.load = 1'b1;
      step();
      bus.load = 1'b0;
   endtask

   // Monitor: pops one expectation per clocked output and checks invariants.
   int cyc, last_frame;
   bit have_prev;
   initial begin
      exp_t e;
      cyc = 0; have_prev = 0; last_frame = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            have_prev = 0;
            continue;
         end
         cyc++;
         check("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("an", 32'(bus.an), 32'(e.an));
            check("seg", 32'(bus.seg), 32'(e.seg));
            check("dp", 32'(bus.dp), 32'(e.dp));
            check("frame", 32'(bus.frame), 32'(e.frame));
         end
         if (bus.frame) begin
            if (have_prev) check("frame_period", 32'(cyc - last_frame), 32'(FRAMEC));
            have_prev = 1;
            last_frame = cyc;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic reset_checks(input string tag);
      check({tag, "_an"}, 32'(bus.an), 32'hF);
      check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
      check({tag, "_dp"}, 32'(bus.dp), 32'd1);
      check({tag, "_frame"}, 32'(bus.frame), 32'd0);
   endtask

   initial begin
      int guard_cnt;
      bus.value = 16'h0; bus.load = 1'b0; bus.blank_lz = 1'b0; bus.dp_en = 4'h0;
      ecnt = 0; mdisp = '0; mshadow = '0;
      #12;
      reset_checks("rst");
      @(negedge clk);
      reset = 1'b0;

      // Zero display, no blanking then blanking.
      run(45);
      bus.blank_lz = 1'b1;
      run(40);
      bus.blank_lz = 1'b0;

      // Mid-frame load of 12AF with dp on digit 2.
      run(7);
      do_load(16'h12AF, 4'b0100);
      run(50);

      // Leading-zero blanking on 0050.
      do_load(16'h0050, 4'b0000);
      bus.blank_lz = 1'b1;
      run(45);
      bus.blank_lz = 1'b0;
      run(40);

      // Load exactly on the wrap edge: next edge is a wrap when ecnt % 20 == 0.
      do_load(16'h3C7E, 4'b0011);
      guard_cnt = 0;
      while (ecnt % FRAMEC != 0 && guard_cnt < 100) begin step(); guard_cnt++; end
      check("wrap_align", 32'(ecnt % FRAMEC), 32'd0);
      do_load(16'h9B04, 4'b1000);
      run(50);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bus.blank_lz = ($urandom_range(0, 15) == 0) ? ~bus.blank_lz : bus.blank_lz;
         if ($urandom_range(0, 7) == 0) begin
            bus.value = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            bus.dp_en = 4'($urandom);
            bus.load = 1'b1;
         end else begin
            bus.load = 1'b0;
         end
         step();
      end
      bus.load = 1'b0;
      do_load(16'h0000, 4'b1010);
      bus.blank_lz = 1'b1;
      run(45);

      // Reset during digit 2 SHOW, then load on the release edge.
      guard_cnt = 0;
      while (!(ecnt >= 2 && ((ecnt - 2) % FRAMEC) / SLOT == 2 && ((ecnt - 2) % SLOT) == 1)
             && guard_cnt < 100) begin
         step(); guard_cnt++;
      end
      check("digit2_an", 32'(bus.an), 32'hB);
      #2;
      reset = 1'b1;
      #1;
      reset_checks("midrst");
      sb_q.delete();
      ecnt = 0; mdisp = '0; mshadow = '0;
      @(negedge clk);
      bus.value = 16'hABCD; bus.dp_en = 4'b0001; bus.load = 1'b1;
      reset = 1'b0;
      step();
      bus.load = 1'b0;
      run(50);

      @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
